serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised multi-cycle ripple adder with valid/ready handshake on input and output.
- Computes a + b + cin over WIDTH bits, BITS_PER_CYCLE bits per clock, through a chain of full-adder cells and a registered carry.
- Trades area for latency; used wherever a wide adder need not finish in one cycle.
- Also reports carry-out and signed overflow.

Parameters:
- WIDTH, 8, operand and sum width in bits (>= 2).
- BITS_PER_CYCLE, 1, bits added per clock; must divide WIDTH exactly (elaboration-time check, fatal on violation).
- STEPS, WIDTH/BITS_PER_CYCLE, derived (localparam), number of compute cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  output  1  unsigned carry-out.
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (clk edge with rst=1): state IDLE, sum=0, cout=0, ovf=0, out_valid=0, step counter=0, carry reg=0. While rst=1, in_ready=0 and all inputs are ignored. Reset mid-RUN or mid-DONE aborts the operation; no result is emitted.
- Accept: transfer occurs on an edge where in_valid && in_ready. a, b and cin are latched into the operand shift registers and carry reg; counter=0; next state RUN.
- in_ready is combinational: 1 in IDLE, or in DONE when out_ready=1. Otherwise 0.
- RUN, each cycle:
  - Add the BITS_PER_CYCLE LSBs of the A/B shift regs plus the carry reg through the cell chain.
  - Shift A/B right by BITS_PER_CYCLE.
  - Shift the result bits into sum from the MSB side.
  - Update the carry reg with the chain carry-out.
  - Increment the counter.
  - On the last step (counter==STEPS-1), record the carry into the MSB and the carry out of the MSB, then go to DONE.
- Latency: operands accepted at edge k, out_valid=1 after edge k+STEPS.
- sum, cout and ovf are not updated while out_valid=0; their values during RUN are don't-care for the consumer.
- DONE:
  - out_valid=1; sum, cout and ovf held stable until the result is consumed (out_valid && out_ready).
  - On consume without a new accept, go to IDLE; out_valid=0 next cycle.
  - On consume with a simultaneous accept, go directly to RUN with the new operands. out_valid=0 next cycle. Back-to-back throughput is one result per STEPS+1 cycles.
- in_valid in RUN is ignored (in_ready=0); operand changes during RUN do not affect the result.
- State machine: IDLE -> RUN on accept; RUN -> DONE on last step; DONE -> IDLE on consume; DONE -> RUN on consume+accept. Any state -> IDLE on rst.
- Width rules:
  - Arithmetic is unsigned modulo 2^WIDTH.
  - cout = bit WIDTH of the full sum.
  - ovf per two's-complement rule, independent of cout.

Decomposition:
- Shared package (adder_pkg): state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2; helper function for the clog2 counter width.
- One sub-module: full_adder_cell (a, b, ci -> s, co, purely combinational), instantiated BITS_PER_CYCLE times in a generate chain.
- Top holds FSM, counter, shift registers, carry reg and output registers.

Test Plan:
- WIDTH=8, BPC=1: a=8'hFF, b=8'h01, cin=0 -> out_valid exactly 8 cycles after accept; sum=8'h00, cout=1, ovf=0.
- WIDTH=8, BPC=1: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum, cout and ovf stable, in_ready=0 throughout. Raise out_ready -> out_valid drops the next cycle.
- Back-to-back: in DONE, assert out_ready and in_valid together with a=8'h10, b=8'h20 -> first result consumed and new operands accepted on the same edge; second sum=8'h30 arrives 8 cycles later.
- Reset mid-operation: assert rst at step 3 of a=8'h55 + b=8'h55 -> next cycle out_valid=0, sum=0, in_ready=1 after rst drops; no stale result ever appears. A fresh 8'h01+8'h01 then yields sum=8'h02.
- WIDTH=8, BPC=4: a=8'hA5, b=8'h5A, cin=1 -> latency 2 cycles; sum=8'h00, cout=1, ovf=0. Compare against a random 200-vector reference model for BPC in {1,2,8}.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared state encoding and sizing helper for the serial adder and its bench.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter width; never zero so a single-step configuration still elaborates.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder; chained BITS_PER_CYCLE deep inside the serial adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle ripple adder: adds BITS_PER_CYCLE bits per clock behind valid/ready
// handshakes, reporting sum, unsigned carry-out and signed overflow.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
        $fatal(1, "serial_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    logic                      carry;
    logic [BITS_PER_CYCLE:0]   c;
    logic [BITS_PER_CYCLE-1:0] s;
    logic [WIDTH-1:0]          sum_next;
    logic                      accept;

    // Ripple chain over the low slice of the operand shift registers.
    assign c[0] = carry;
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a_sh[i]),
            .b  (b_sh[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // New result bits enter from the MSB side; after STEPS shifts sum is aligned.
    assign sum_next = WIDTH'({s, sum} >> BITS_PER_CYCLE);

    assign in_ready = !rst && ((state == IDLE) || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;

    // NOTE: every register here uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> BITS_PER_CYCLE;
                    b_sh  <= b_sh >> BITS_PER_CYCLE;
                    sum   <= sum_next;
                    carry <= c[BITS_PER_CYCLE];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Last slice holds the MSB: its carry-in vs carry-out gives overflow.
                        cout      <= c[BITS_PER_CYCLE];
                        ovf       <= c[BITS_PER_CYCLE-1] ^ c[BITS_PER_CYCLE];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            a_sh  <= a;
                            b_sh  <= b;
                            carry <= cin;
                            cnt   <= '0;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 with BITS_PER_CYCLE of 1, 2, 4 and 8.
module tb_serial_adder;

    localparam int W = 8;
    localparam int N = 4;

    typedef struct packed {
        logic [1:0]   idx;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        iv;
    logic [N-1:0]        ordy;
    logic [N-1:0]        ir;
    logic [N-1:0]        ov;
    logic [N-1:0]        co;
    logic [N-1:0]        of;
    logic [N-1:0][W-1:0] sm;
    logic [W-1:0]        a;
    logic [W-1:0]        b;
    logic                cin;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Instance g uses BITS_PER_CYCLE = 2**g; operands are shared, handshakes are not.
    for (genvar g = 0; g < N; g++) begin : g_dut
        serial_adder #(.WIDTH(W), .BITS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .sum       (sm[g]),
            .cout      (co[g]),
            .ovf       (of[g])
        );
    end

    // Scoreboard: every consumed result must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (ov[i] && ordy[i]) begin
                    n_vec++;
                    got = '{idx: 2'(i), sum: sm[i], cout: co[i], ovf: of[i]};
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected: inst%0d delivered sum=%h cout=%b ovf=%b, no result was pending",
                                 i, sm[i], co[i], of[i]);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            n_err++;
                            $display("FAIL sb_result: got inst%0d sum=%h cout=%b ovf=%b, required inst%0d sum=%h cout=%b ovf=%b",
                                     got.idx, got.sum, got.cout, got.ovf, e.idx, e.sum, e.cout, e.ovf);
                        end
                    end
                end
            end
        end
    end

    function automatic exp_t model(input int idx, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                   input logic tc);
        logic [W:0] full;
        exp_t       e;
        full   = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
        e.idx  = 2'(idx);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (ta[W-1] == tb_[W-1]) && (full[W-1] != ta[W-1]);
        return e;
    endfunction

    function automatic exp_t mk(input int idx, input logic [W-1:0] s, input logic c, input logic o);
        return '{idx: 2'(idx), sum: s, cout: c, ovf: o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands to one instance and return just after the accepting edge.
    task automatic send(input int idx, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input bit push, input exp_t e);
        int guard = 0;
        a = ta;
        b = tb_;
        cin = tc;
        iv[idx] = 1'b1;
        #1;
        while (!ir[idx] && guard < 64) begin
            tick();
            guard++;
        end
        if (!ir[idx]) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: inst%0d in_ready=0 after %0d cycles, required 1", idx, guard);
        end
        if (push) exp_q.push_back(e);
        tick();
        iv[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx, output int lat);
        lat = 0;
        while (!ov[idx] && lat < 64) begin
            tick();
            lat++;
        end
        if (!ov[idx]) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: inst%0d out_valid=0 after %0d cycles, required 1", idx, lat);
            lat = -1;
        end
    endtask

    task automatic consume(input int idx);
        ordy[idx] = 1'b1;
        tick();
        ordy[idx] = 1'b0;
        n_vec++;
        if (ov[idx] !== 1'b0) begin
            n_err++;
            $display("FAIL valid_drop: inst%0d out_valid=%b after consume, required 0", idx, ov[idx]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv = '0;
        ordy = '0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (2) tick();
        n_vec++;
        if (ov !== '0) begin
            n_err++;
            $display("FAIL reset_valid: out_valid=%b, required 0000", ov);
        end
        n_vec++;
        if (sm !== '0 || co !== '0 || of !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b, required all zero", sm, co, of);
        end
        n_vec++;
        if (ir !== '0) begin
            n_err++;
            $display("FAIL reset_ready: in_ready=%b during reset, required 0000", ir);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (ir !== '1) begin
            n_err++;
            $display("FAIL idle_ready: in_ready=%b after reset, required 1111", ir);
        end
    endtask

    task automatic test_carry();
        int lat;
        send(0, 8'hFF, 8'h01, 1'b0, 1'b1, mk(0, 8'h00, 1'b1, 1'b0));
        wait_done(0, lat);
        n_vec++;
        if (lat != 8) begin
            n_err++;
            $display("FAIL latency_bpc1: got %0d cycles, required 8", lat);
        end
        consume(0);
    endtask

    task automatic test_overflow();
        int lat;
        send(0, 8'h7F, 8'h01, 1'b0, 1'b1, mk(0, 8'h80, 1'b0, 1'b1));
        wait_done(0, lat);
        consume(0);
        send(0, 8'h80, 8'h80, 1'b0, 1'b1, mk(0, 8'h00, 1'b1, 1'b1));
        wait_done(0, lat);
        consume(0);
    endtask

    task automatic test_backpressure();
        int lat;
        send(0, 8'h12, 8'h34, 1'b0, 1'b1, mk(0, 8'h46, 1'b0, 1'b0));
        wait_done(0, lat);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || sm[0] !== 8'h46 || co[0] !== 1'b0 || of[0] !== 1'b0) begin
                n_err++;
                $display("FAIL hold_%0d: valid=%b ready=%b sum=%h cout=%b ovf=%b, required 1 0 46 0 0",
                         i, ov[0], ir[0], sm[0], co[0], of[0]);
            end
            tick();
        end
        consume(0);
    endtask

    task automatic test_back_to_back();
        int lat;
        send(0, 8'h03, 8'h04, 1'b1, 1'b1, mk(0, 8'h08, 1'b0, 1'b0));
        wait_done(0, lat);
        a = 8'h10;
        b = 8'h20;
        cin = 1'b0;
        iv[0] = 1'b1;
        ordy[0] = 1'b1;
        #1;
        n_vec++;
        if (ir[0] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready: in_ready=%b in DONE with out_ready=1, required 1", ir[0]);
        end
        exp_q.push_back(mk(0, 8'h30, 1'b0, 1'b0));
        tick();
        iv[0] = 1'b0;
        ordy[0] = 1'b0;
        n_vec++;
        if (ov[0] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_valid: out_valid=%b after consume+accept, required 0", ov[0]);
        end
        wait_done(0, lat);
        n_vec++;
        if (lat != 8) begin
            n_err++;
            $display("FAIL b2b_latency: got %0d cycles, required 8", lat);
        end
        consume(0);
    endtask

    task automatic test_reset_mid();
        int  lat;
        logic seen = 1'b0;
        send(0, 8'h55, 8'h55, 1'b0, 1'b0, mk(0, 8'h00, 1'b0, 1'b0));
        repeat (3) tick();
        rst = 1'b1;
        ordy[0] = 1'b1;
        tick();
        n_vec++;
        if (ov[0] !== 1'b0 || sm[0] !== 8'h00 || ir[0] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state: valid=%b sum=%h ready=%b, required 0 00 0", ov[0], sm[0], ir[0]);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (ir[0] !== 1'b1) begin
            n_err++;
            $display("FAIL abort_ready: in_ready=%b after reset release, required 1", ir[0]);
        end
        for (int i = 0; i < 12; i++) begin
            seen |= ov[0];
            tick();
        end
        ordy[0] = 1'b0;
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_stale: out_valid=%b seen after abort, required 0", seen);
        end
        send(0, 8'h01, 8'h01, 1'b0, 1'b1, mk(0, 8'h02, 1'b0, 1'b0));
        wait_done(0, lat);
        consume(0);
    endtask

    task automatic test_bpc4();
        int lat;
        send(2, 8'hA5, 8'h5A, 1'b1, 1'b1, mk(2, 8'h00, 1'b1, 1'b0));
        wait_done(2, lat);
        n_vec++;
        if (lat != 2) begin
            n_err++;
            $display("FAIL latency_bpc4: got %0d cycles, required 2", lat);
        end
        consume(2);
    endtask

    task automatic test_random();
        int          lat;
        int          sel;
        int          idx;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic        rc;
        for (int v = 0; v < 200; v++) begin
            sel = int'($urandom_range(0, 2));
            idx = (sel == 2) ? 3 : sel;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            send(idx, ra, rb, rc, 1'b1, model(idx, ra, rb, rc));
            wait_done(idx, lat);
            n_vec++;
            if (lat != (8 >> idx)) begin
                n_err++;
                $display("FAIL rand_latency: inst%0d got %0d cycles, required %0d", idx, lat, 8 >> idx);
            end
            repeat ($urandom_range(0, 2)) tick();
            consume(idx);
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_bpc4();
        test_random();
        repeat (2) tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d results still pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
